// File: rtl/fpu_mul_sequencer_pkg.sv
// Shared types and constants for the FP16 multiply issue/retire stage.
package fpu_mul_sequencer_pkg;

    typedef logic [15:0] fp16_t;

    // Condition codes reported by the multiplier: negative, zero, carry, overflow.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } condCode_t;

    // IEEE-style exception flags reported by the multiplier.
    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    // One queued multiply request.
    typedef struct packed {
        fp16_t a;
        fp16_t b;
    } operand_pair_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seqState_t;

endpackage

// File: rtl/fpu_mul_sequencer_if.sv
// Operand input, multiplier handshake and result output bundle.
// Sticky flag signals exist only when STICKY_FLAGS_EN is defined.
interface fpu_mul_sequencer_if;
    import fpu_mul_sequencer_pkg::*;

    logic          in_valid;
    logic          in_ready;
    fp16_t         in_a;
    fp16_t         in_b;
    logic          mul_start;
    logic          mul_reset;
    fp16_t         mul_in1;
    fp16_t         mul_in2;
    logic          mul_done;
    fp16_t         mul_out;
    condCode_t     mul_cc;
    opStatusFlag_t mul_flags;
    logic          out_valid;
    logic          out_ready;
    fp16_t         out_result;
    condCode_t     out_cc;
    opStatusFlag_t out_flags;
    logic          out_err;
`ifdef STICKY_FLAGS_EN
    logic          sticky_clr;
    opStatusFlag_t sticky;
`endif

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_out, mul_cc, mul_flags, out_ready,
        output in_ready, mul_start, mul_reset, mul_in1, mul_in2,
               out_valid, out_result, out_cc, out_flags, out_err
`ifdef STICKY_FLAGS_EN
        , input sticky_clr
        , output sticky
`endif
    );

    // Environment side: operand source, multiplier and result consumer.
    modport master (
        output in_valid, in_a, in_b, mul_done, mul_out, mul_cc, mul_flags, out_ready,
        input  in_ready, mul_start, mul_reset, mul_in1, mul_in2,
               out_valid, out_result, out_cc, out_flags, out_err
`ifdef STICKY_FLAGS_EN
        , output sticky_clr
        , input sticky
`endif
    );

endinterface

// File: rtl/fpu_mul_sequencer_fifo.sv
// Operand-pair FIFO; DEPTH must be a power of two so pointers wrap naturally.
module fpu_operand_fifo
    import fpu_mul_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  operand_pair_t            wdata,
    output operand_pair_t            rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    operand_pair_t   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign rdata = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_mul_sequencer.sv
// Issue/retire stage around the FP16 multiplier: operand FIFO, start/done
// sequencing, watchdog abort and a valid/ready result register.
// Optional feature macro: STICKY_FLAGS_EN (accumulates retired status flags).
module fpu_mul_sequencer
    import fpu_mul_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    fpu_mul_sequencer_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    seqState_t      state;
    seqState_t      next_state;
    logic [CW-1:0]  count;
    logic [TW-1:0]  wd_cnt;
    operand_pair_t  fifo_wdata;
    operand_pair_t  fifo_rdata;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_nonempty;
    logic           wd_expired;
    logic           load_done;
    logic           load_abort;
    logic           abort_q;

    assign fifo_wdata    = {bus.in_a, bus.in_b};
    assign fifo_push     = bus.in_valid && bus.in_ready;
    assign fifo_nonempty = (count != '0);
    assign wd_expired    = (wd_cnt == TW'(TIMEOUT - 1));

    // Full FIFO refuses input even if a pop is happening this cycle.
    assign bus.in_ready  = (count != CW'(DEPTH));

    // Multiplier is held in reset with the block, and kicked once on abort.
    assign bus.mul_reset = ~reset | abort_q;

    fpu_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (count)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fifo_nonempty) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (bus.mul_done || wd_expired) next_state = HOLD;
            HOLD:    if (bus.out_ready) next_state = fifo_nonempty ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control decode: FIFO pop and result-register load selects.
    always_comb begin
        fifo_pop   = 1'b0;
        load_done  = 1'b0;
        load_abort = 1'b0;
        case (state)
            IDLE: fifo_pop = fifo_nonempty;
            WAIT: begin
                load_done  = bus.mul_done;
                load_abort = !bus.mul_done && wd_expired;
            end
            HOLD: fifo_pop = bus.out_ready && fifo_nonempty;
            default: ;
        endcase
    end

    // Operand registers, start pulse, watchdog and result register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mul_in1    <= '0;
            bus.mul_in2    <= '0;
            bus.mul_start  <= 1'b0;
            wd_cnt         <= '0;
            abort_q        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_cc     <= '0;
            bus.out_flags  <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            bus.mul_start <= fifo_pop;
            abort_q       <= load_abort;
            if (fifo_pop) begin
                bus.mul_in1 <= fifo_rdata.a;
                bus.mul_in2 <= fifo_rdata.b;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + TW'(1);
            end
            if (load_done) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= bus.mul_out;
                bus.out_cc     <= bus.mul_cc;
                bus.out_flags  <= bus.mul_flags;
                bus.out_err    <= 1'b0;
            end else if (load_abort) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= FP16_QNAN;
                bus.out_cc     <= '0;
                bus.out_flags  <= '0;
                bus.out_err    <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                bus.out_valid  <= 1'b0;
            end
        end
    end

`ifdef STICKY_FLAGS_EN
    // Sticky flags: OR of every retired result's flags; clear has priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.sticky <= '0;
        end else if (bus.sticky_clr) begin
            bus.sticky <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.sticky <= opStatusFlag_t'(bus.sticky | bus.out_flags);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// Directed bench for fpu_mul_sequencer with a latency-5 multiplier stand-in.
module tb_fpu_mul_sequencer;
    import fpu_mul_sequencer_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TIMEOUT   = 16;
    localparam int          MODEL_LAT = 5;

    typedef struct {
        fp16_t         a;
        fp16_t         b;
        condCode_t     cc;
        opStatusFlag_t flags;
        fp16_t         exp_result;
        condCode_t     exp_cc;
        opStatusFlag_t exp_flags;
    } vec_t;

    logic clock;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    logic          model_hang;
    condCode_t     model_cc;
    opStatusFlag_t model_flags;

    fpu_mul_sequencer_if ifc ();

    fpu_mul_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: exact products for the operand pairs used here.
    function automatic fp16_t model_mul(input fp16_t a, input fp16_t b);
        if (a == 16'h3C00) return b;
        case ({a, b})
            32'h4200_4400: return 16'h4A00;
            32'h3800_3800: return 16'h3400;
            32'h4000_4000: return 16'h4400;
            32'hC000_4000: return 16'hC400;
            default:       return 16'h7C00;
        endcase
    endfunction

    // Multiplier model: done pulses MODEL_LAT negedges after start is seen.
    initial begin
        int cnt;
        cnt           = 0;
        ifc.mul_done  = 1'b0;
        ifc.mul_out   = '0;
        ifc.mul_cc    = '0;
        ifc.mul_flags = '0;
        forever begin
            @(negedge clock);
            if (ifc.mul_reset) begin
                cnt          = 0;
                ifc.mul_done = 1'b0;
            end else if (ifc.mul_done) begin
                ifc.mul_done = 1'b0;
            end else if (ifc.mul_start) begin
                cnt = MODEL_LAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !model_hang) begin
                    ifc.mul_done  = 1'b1;
                    ifc.mul_out   = model_mul(ifc.mul_in1, ifc.mul_in2);
                    ifc.mul_cc    = model_cc;
                    ifc.mul_flags = model_flags;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input fp16_t a, input fp16_t b);
        int t;
        t = 0;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) check("push_timeout", 32'(t), 32'(0));
        @(negedge clock);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!ifc.out_valid && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) check(name, 32'(ifc.out_valid), 32'(1));
    endtask

    task automatic handshake();
        ifc.out_ready = 1'b1;
        @(negedge clock);
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl [6];
        fp16_t t3_b [6];
        int    got;
        int    n;

        tbl[0] = '{16'h3C00, 16'h4000, condCode_t'(4'b0000), opStatusFlag_t'(5'b00000),
                   16'h4000, condCode_t'(4'b0000), opStatusFlag_t'(5'b00000)};
        tbl[1] = '{16'h4200, 16'h4400, condCode_t'(4'b0001), opStatusFlag_t'(5'b00001),
                   16'h4A00, condCode_t'(4'b0001), opStatusFlag_t'(5'b00001)};
        tbl[2] = '{16'h3800, 16'h3800, condCode_t'(4'b0010), opStatusFlag_t'(5'b00010),
                   16'h3400, condCode_t'(4'b0010), opStatusFlag_t'(5'b00010)};
        tbl[3] = '{16'h3C00, 16'h3C00, condCode_t'(4'b0000), opStatusFlag_t'(5'b10000),
                   16'h3C00, condCode_t'(4'b0000), opStatusFlag_t'(5'b10000)};
        tbl[4] = '{16'h4000, 16'h4000, condCode_t'(4'b0100), opStatusFlag_t'(5'b01000),
                   16'h4400, condCode_t'(4'b0100), opStatusFlag_t'(5'b01000)};
        tbl[5] = '{16'hC000, 16'h4000, condCode_t'(4'b1000), opStatusFlag_t'(5'b00100),
                   16'hC400, condCode_t'(4'b1000), opStatusFlag_t'(5'b00100)};
        t3_b = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};

        reset         = 1'b0;
        model_hang    = 1'b0;
        model_cc      = '0;
        model_flags   = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b0;
`ifdef STICKY_FLAGS_EN
        ifc.sticky_clr = 1'b0;
`endif

        // Reset state
        #2;
        check("rst_out_valid", 32'(ifc.out_valid), 32'(0));
        check("rst_in_ready", 32'(ifc.in_ready), 32'(1));
        check("rst_mul_reset", 32'(ifc.mul_reset), 32'(1));
        check("rst_mul_start", 32'(ifc.mul_start), 32'(0));
        check("rst_out_result", 32'(ifc.out_result), 32'(0));
        check("rst_out_err", 32'(ifc.out_err), 32'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rel_mul_reset", 32'(ifc.mul_reset), 32'(0));

        // 1: start latency and first result
        push(16'h3C00, 16'h4000);
        check("t1_start_early", 32'(ifc.mul_start), 32'(0));
        @(negedge clock);
        check("t1_start", 32'(ifc.mul_start), 32'(1));
        check("t1_in1", 32'(ifc.mul_in1), 32'h3C00);
        check("t1_in2", 32'(ifc.mul_in2), 32'h4000);
        @(negedge clock);
        check("t1_start_once", 32'(ifc.mul_start), 32'(0));
        wait_valid("t1_valid_timeout");
        check("t1_result", 32'(ifc.out_result), 32'h4000);
        check("t1_err", 32'(ifc.out_err), 32'(0));
        @(negedge clock);
        check("t1_hold", 32'(ifc.out_result), 32'h4000);
        check("t1_hold_valid", 32'(ifc.out_valid), 32'(1));
        handshake();
        check("t1_retired", 32'(ifc.out_valid), 32'(0));

        // Table of single operations
        for (int i = 0; i < 6; i++) begin
            model_cc    = tbl[i].cc;
            model_flags = tbl[i].flags;
            push(tbl[i].a, tbl[i].b);
            wait_valid("vec_valid_timeout");
            check("vec_result", 32'(ifc.out_result), 32'(tbl[i].exp_result));
            check("vec_cc", 32'(ifc.out_cc), 32'(tbl[i].exp_cc));
            check("vec_flags", 32'(ifc.out_flags), 32'(tbl[i].exp_flags));
            check("vec_err", 32'(ifc.out_err), 32'(0));
            handshake();
        end
        model_cc    = '0;
        model_flags = '0;

        // 2: back-to-back pushes with consumer always ready
        ifc.out_ready = 1'b1;
        push(16'h4200, 16'h4400);
        push(16'h3800, 16'h3800);
        wait_valid("t2_valid0_timeout");
        check("t2_result0", 32'(ifc.out_result), 32'h4A00);
        @(negedge clock);
        check("t2_b2b_start", 32'(ifc.mul_start), 32'(1));
        check("t2_valid_drop", 32'(ifc.out_valid), 32'(0));
        wait_valid("t2_valid1_timeout");
        check("t2_result1", 32'(ifc.out_result), 32'h3400);
        @(negedge clock);
        ifc.out_ready = 1'b0;

        // 3: fill the FIFO behind a blocked result, then drain in order
        push(16'h3C00, t3_b[0]);
        @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            push(16'h3C00, t3_b[k]);
            check("t3_in_ready", 32'(ifc.in_ready), 32'(k < 4));
        end
        got = 0;
        fork
            push(16'h3C00, t3_b[5]);
            begin
                ifc.out_ready = 1'b1;
                for (int t = 0; t < 400 && got < 6; t++) begin
                    if (ifc.out_valid) begin
                        check("t3_order", 32'(ifc.out_result), 32'(t3_b[got]));
                        got++;
                    end
                    @(negedge clock);
                end
            end
        join
        check("t3_count", 32'(got), 32'(6));
        ifc.out_ready = 1'b0;

        // 4: watchdog abort
        model_hang = 1'b1;
        push(16'h4000, 16'h4000);
        @(negedge clock);
        check("t4_start", 32'(ifc.mul_start), 32'(1));
        n = 0;
        while (!ifc.mul_reset && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t4_abort_delay", 32'(n), 32'(TIMEOUT + 1));
        check("t4_valid", 32'(ifc.out_valid), 32'(1));
        check("t4_result", 32'(ifc.out_result), 32'h7E00);
        check("t4_err", 32'(ifc.out_err), 32'(1));
        check("t4_cc", 32'(ifc.out_cc), 32'(0));
        check("t4_flags", 32'(ifc.out_flags), 32'(0));
        @(negedge clock);
        check("t4_pulse_once", 32'(ifc.mul_reset), 32'(0));
        check("t4_hold_err", 32'(ifc.out_err), 32'(1));
        handshake();

        // 5: asynchronous reset while WAIT, FIFO full
        push(16'h3C00, 16'h4000);
        @(negedge clock);
        for (int k = 0; k < 4; k++) push(16'h3C00, 16'h4200);
        check("t5_full", 32'(ifc.in_ready), 32'(0));
        #2;
        reset = 1'b0;
        #1;
        check("t5_out_valid", 32'(ifc.out_valid), 32'(0));
        check("t5_in_ready", 32'(ifc.in_ready), 32'(1));
        check("t5_mul_reset", 32'(ifc.mul_reset), 32'(1));
        @(negedge clock);
        reset      = 1'b1;
        model_hang = 1'b0;
        @(negedge clock);
        push(16'h3C00, 16'h3C00);
        wait_valid("t5_valid_timeout");
        check("t5_result", 32'(ifc.out_result), 32'h3C00);
        check("t5_err", 32'(ifc.out_err), 32'(0));
        handshake();
        n = 0;
        for (int t = 0; t < 30; t++) begin
            if (ifc.out_valid) n++;
            @(negedge clock);
        end
        check("t5_flushed", 32'(n), 32'(0));

`ifdef STICKY_FLAGS_EN
        // 6: sticky flag accumulation and clear
        ifc.sticky_clr = 1'b1;
        @(negedge clock);
        ifc.sticky_clr = 1'b0;
        check("t6_clr0", 32'(ifc.sticky), 32'(0));
        model_flags = opStatusFlag_t'(5'b00001);
        push(16'h3C00, 16'h4000);
        wait_valid("t6_valid0_timeout");
        handshake();
        model_flags = opStatusFlag_t'(5'b00100);
        push(16'h3C00, 16'h4200);
        wait_valid("t6_valid1_timeout");
        check("t6_pre_hs", 32'(ifc.sticky), 32'h01);
        handshake();
        check("t6_or", 32'(ifc.sticky), 32'h05);
        ifc.sticky_clr = 1'b1;
        @(negedge clock);
        ifc.sticky_clr = 1'b0;
        check("t6_clr", 32'(ifc.sticky), 32'(0));
        model_flags = opStatusFlag_t'(5'b00010);
        push(16'h3C00, 16'h4400);
        wait_valid("t6_valid2_timeout");
        ifc.sticky_clr = 1'b1;
        handshake();
        ifc.sticky_clr = 1'b0;
        check("t6_clr_wins", 32'(ifc.sticky), 32'(0));
        model_flags = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
